mod_butterfly_pipe: RTL and testbench

//  Runtime-twiddle, modulus-parametrised NTT butterfly with elastic valid/ready pipeline.

---
 rtl/ntt_pkg.sv | 19 +
 rtl/mod_mul_barrett.sv | 62 ++++++
 rtl/mod_butterfly_pipe.sv | 161 ++++++++++++++++
 tb/tb_mod_butterfly_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared mode encodings, moduli and the Barrett constant helper for the NTT butterfly datapath.
package ntt_pkg;

  typedef enum logic [1:0] {
    MODE_CT  = 2'b00,
    MODE_GS  = 2'b01,
    MODE_MUL = 2'b10,
    MODE_BYP = 2'b11
  } mode_e;

  localparam int Q_KYBER     = 3329;
  localparam int Q_DILITHIUM = 8380417;

  // floor(2^(2W)/Q); 64 bits is enough for the W=23 Dilithium case.
  function automatic logic [63:0] barrett_m(input int q, input int w);
    return (64'd1 << (2 * w)) / 64'(q);
  endfunction

endpackage

// File: rtl/mod_mul_barrett.sv
// Pipelined W x W multiply followed by Barrett reduction mod Q; all stages advance on en_i.
module mod_mul_barrett
  import ntt_pkg::*;
#(
  parameter int W      = 12,
  parameter int Q      = Q_KYBER,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] r_o
);

  localparam int         K  = 2 * W;
  localparam logic [W:0] M  = (W+1)'(barrett_m(Q, W));
  localparam logic [W:0] QX = (W+1)'(Q);

  logic [2*W-1:0] prod_q;
  logic [3*W:0]   pm;
  logic [W:0]     quot;
  logic [2*W-1:0] qq;
  logic [W:0]     rem;
  logic [W-1:0]   rem_red;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (en_i) begin
      prod_q <= (2*W)'(x_i) * (2*W)'(y_i);
    end
  end

  // The quotient estimate is at most one short, so the remainder is below 2Q.
  assign pm      = (3*W+1)'(prod_q) * (3*W+1)'(M);
  assign quot    = (W+1)'(pm >> K);
  assign qq      = (2*W)'(quot) * (2*W)'(Q);
  assign rem     = (W+1)'(prod_q - qq);
  assign rem_red = (rem >= QX) ? W'(rem - QX) : W'(rem);

  generate
    if (STAGES == 1) begin : g_one
      assign r_o = rem_red;
    end else begin : g_pipe
      logic [W-1:0] pipe_q [STAGES-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES - 1; i++) pipe_q[i] <= '0;
        end else if (en_i) begin
          pipe_q[0] <= rem_red;
          for (int i = 1; i < STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign r_o = pipe_q[STAGES-2];
    end
  endgenerate

endmodule

// File: rtl/mod_butterfly_pipe.sv
// Runtime-twiddle NTT butterfly (CT / GS / MUL / BYPASS) with an elastic valid/ready pipeline.
module mod_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int Q          = Q_KYBER,
  parameter int W          = 12,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     twiddle,
  input  logic [W-1:0]     IN_1,
  input  logic [W-1:0]     IN_2,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [W-1:0]     U_OUT,
  output logic [W-1:0]     V_OUT,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int         LAT = MUL_STAGES + 1;
  localparam logic [W:0] QX  = (W+1)'(Q);

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= QX) ? W'(s - QX) : W'(s);
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    return d[W] ? W'(d + QX) : W'(d);
  endfunction

  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
    logic [W:0] h;
    h = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
    return W'(h >> 1);
  endfunction

  logic             adv;
  logic [LAT-1:0]   sb_valid_q;
  mode_e            sb_mode_q [LAT];
  logic [TAG_W-1:0] sb_tag_q  [LAT];
  logic [W-1:0]     sb_a_q    [LAT];
  logic [W-1:0]     x0_q, y0_q;
  logic [W-1:0]     a0_d, x0_d, y0_d;
  logic [W-1:0]     t;
  logic [W-1:0]     u_d, v_d;
  logic             valid_out_q;
  logic [W-1:0]     u_q, v_q;
  logic [TAG_W-1:0] tag_out_q;

  assign adv      = ~valid_out_q | ready_out;
  assign ready_in = adv;

  // Stage 0 steers the multiplier: BYPASS sends b through as b*1 so it needs no side path.
  always_comb begin
    a0_d = IN_1;
    x0_d = IN_2;
    y0_d = twiddle;
    case (mode_e'(mode))
      MODE_GS: begin
        a0_d = add_mod(IN_1, IN_2);
        x0_d = sub_mod(IN_1, IN_2);
      end
      MODE_MUL: y0_d = IN_1;
      MODE_BYP: y0_d = W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      sb_valid_q <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      for (int i = 0; i < LAT; i++) begin
        sb_mode_q[i] <= MODE_CT;
        sb_tag_q[i]  <= '0;
        sb_a_q[i]    <= '0;
      end
    end else if (adv) begin
      sb_valid_q[0] <= valid_in;
      sb_mode_q[0]  <= mode_e'(mode);
      sb_tag_q[0]   <= tag_in;
      sb_a_q[0]     <= a0_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      for (int i = 1; i < LAT; i++) begin
        sb_valid_q[i] <= sb_valid_q[i-1];
        sb_mode_q[i]  <= sb_mode_q[i-1];
        sb_tag_q[i]   <= sb_tag_q[i-1];
        sb_a_q[i]     <= sb_a_q[i-1];
      end
    end
  end

  mod_mul_barrett #(
    .W      (W),
    .Q      (Q),
    .STAGES (MUL_STAGES)
  ) u_mul (
    .clk   (clk),
    .rst_n (r),
    .en_i  (adv),
    .x_i   (x0_q),
    .y_i   (y0_q),
    .r_o   (t)
  );

  always_comb begin
    u_d = sb_a_q[LAT-1];
    v_d = t;
    case (sb_mode_q[LAT-1])
      MODE_CT: begin
        u_d = add_mod(sb_a_q[LAT-1], t);
        v_d = sub_mod(sb_a_q[LAT-1], t);
      end
      MODE_GS: begin
        u_d = half_mod(sb_a_q[LAT-1]);
        v_d = half_mod(t);
      end
      MODE_MUL: begin
        u_d = t;
        v_d = sb_a_q[LAT-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      valid_out_q <= 1'b0;
      u_q         <= '0;
      v_q         <= '0;
      tag_out_q   <= '0;
    end else if (adv) begin
      valid_out_q <= sb_valid_q[LAT-1];
      if (sb_valid_q[LAT-1]) begin
        u_q       <= u_d;
        v_q       <= v_d;
        tag_out_q <= sb_tag_q[LAT-1];
      end
    end
  end

  assign valid_out = valid_out_q;
  assign U_OUT     = u_q;
  assign V_OUT     = v_q;
  assign tag_out   = tag_out_q;
  assign busy      = valid_out_q | (|sb_valid_q);

endmodule

// File: tb/tb_mod_butterfly_pipe.sv
// Scoreboard bench: a Kyber and a Dilithium butterfly instance, directed vectors plus random beats.
module tb_mod_butterfly_pipe;
   import ntt_pkg::*;

   typedef struct {
      longint unsigned u;
      longint unsigned v;
      logic [7:0]      tag;
   } exp_t;

   logic clk;
   logic r;

   logic        kValidIn, kReadyIn, kValidOut, kReadyOut, kBusy;
   logic [1:0]  kMode;
   logic [11:0] kTw, kIn1, kIn2, kU, kV;
   logic [7:0]  kTagIn, kTagOut;

   logic        dValidIn, dReadyIn, dValidOut, dReadyOut, dBusy;
   logic [1:0]  dMode;
   logic [22:0] dTw, dIn1, dIn2, dU, dV;
   logic [7:0]  dTagIn, dTagOut;

   exp_t qK[$];
   exp_t qD[$];
   int   checks = 0;
   int   passes = 0;
   bit   kRandReady = 0;
   bit   dRandReady = 0;

   mod_butterfly_pipe #(.Q(Q_KYBER), .W(12), .MUL_STAGES(2), .TAG_W(8)) dutKyber (
      .clk(clk), .r(r), .valid_in(kValidIn), .ready_in(kReadyIn), .mode(kMode),
      .twiddle(kTw), .IN_1(kIn1), .IN_2(kIn2), .tag_in(kTagIn), .valid_out(kValidOut),
      .ready_out(kReadyOut), .U_OUT(kU), .V_OUT(kV), .tag_out(kTagOut), .busy(kBusy)
   );

   mod_butterfly_pipe #(.Q(Q_DILITHIUM), .W(23), .MUL_STAGES(2), .TAG_W(8)) dutDil (
      .clk(clk), .r(r), .valid_in(dValidIn), .ready_in(dReadyIn), .mode(dMode),
      .twiddle(dTw), .IN_1(dIn1), .IN_2(dIn2), .tag_in(dTagIn), .valid_out(dValidOut),
      .ready_out(dReadyOut), .U_OUT(dU), .V_OUT(dV), .tag_out(dTagOut), .busy(dBusy)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Independent reference arithmetic using plain integer remainders.
   function automatic longint unsigned halfRef(input longint unsigned x, input longint unsigned q);
      return (x % 2 == 0) ? x / 2 : (x + q) / 2;
   endfunction

   function automatic void refModel(input logic [1:0] md, input longint unsigned a, input longint unsigned b,
                                    input longint unsigned w, input longint unsigned q,
                                    output longint unsigned u, output longint unsigned v);
      longint unsigned t, s, d;
      case (md)
         2'b00: begin
            t = (w * b) % q;
            u = (a + t) % q;
            v = (a + q - t) % q;
         end
         2'b01: begin
            s = (a + b) % q;
            d = (a + q - b) % q;
            t = (w * d) % q;
            u = halfRef(s, q);
            v = halfRef(t, q);
         end
         2'b10: begin
            u = (a * b) % q;
            v = a;
         end
         default: begin
            u = a;
            v = b;
         end
      endcase
   endfunction

   task automatic checkValue(input string name, input longint unsigned got, input longint unsigned want);
      checks++;
      if (got == want) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
   endtask

   // Pops the oldest expected beat of an instance and compares it with what the DUT presents.
   task automatic checkOutput(input int inst, input longint unsigned u, input longint unsigned v, input logic [7:0] tg);
      exp_t e;
      checks++;
      if ((inst == 0 && qK.size() == 0) || (inst == 1 && qD.size() == 0)) begin
         $display("[TB] FAIL unexpected_beat inst%0d: got U=%0d V=%0d tag=%0d, expected no beat", inst, u, v, tg);
         return;
      end
      if (inst == 0) e = qK.pop_front();
      else e = qD.pop_front();
      if (e.u == u && e.v == v && e.tag == tg) passes++;
      else $display("[TB] FAIL beat inst%0d: got U=%0d V=%0d tag=%0d, expected U=%0d V=%0d tag=%0d",
                    inst, u, v, tg, e.u, e.v, e.tag);
   endtask

   // Entered and left at posedge+1; holds the beat until it is accepted and records the expectation.
   task automatic applyStimulus(input int inst, input logic [1:0] md, input longint unsigned a,
                                input longint unsigned b, input longint unsigned w, input logic [7:0] tg,
                                input longint unsigned eu, input longint unsigned ev);
      exp_t e;
      bit   done;
      e.u = eu;
      e.v = ev;
      e.tag = tg;
      if (inst == 0) begin
         kValidIn = 1'b1; kMode = md; kIn1 = a[11:0]; kIn2 = b[11:0]; kTw = w[11:0]; kTagIn = tg;
      end else begin
         dValidIn = 1'b1; dMode = md; dIn1 = a[22:0]; dIn2 = b[22:0]; dTw = w[22:0]; dTagIn = tg;
      end
      done = 1'b0;
      for (int c = 0; c < 1000 && !done; c++) begin
         @(negedge clk);
         if (inst == 0 && kReadyIn) begin
            qK.push_back(e);
            done = 1'b1;
         end else if (inst == 1 && dReadyIn) begin
            qD.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (inst == 0) kValidIn = 1'b0;
      else dValidIn = 1'b0;
      if (!done) begin
         checks++;
         $display("[TB] FAIL accept_timeout inst%0d: got no acceptance of tag %0d, expected acceptance within 1000 cycles", inst, tg);
      end
   endtask

   task automatic waitDrain(input int inst, input string name);
      int left;
      left = (inst == 0) ? qK.size() : qD.size();
      for (int c = 0; c < 2000 && left != 0; c++) begin
         @(posedge clk);
         #1;
         left = (inst == 0) ? qK.size() : qD.size();
      end
      checkValue(name, longint'(left), 0);
   endtask

   always @(negedge clk) if (r && kValidOut && kReadyOut) checkOutput(0, kU, kV, kTagOut);
   always @(negedge clk) if (r && dValidOut && dReadyOut) checkOutput(1, dU, dV, dTagOut);

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (kRandReady) kReadyOut = 1'($urandom_range(0, 1));
         if (dRandReady) dReadyOut = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      longint unsigned a, b, w, eu, ev;
      logic [1:0] md;
      int lat, seen;

      r = 1'b0;
      kValidIn = 0; kMode = 0; kTw = 0; kIn1 = 0; kIn2 = 0; kTagIn = 0; kReadyOut = 1'b1;
      dValidIn = 0; dMode = 0; dTw = 0; dIn1 = 0; dIn2 = 0; dTagIn = 0; dReadyOut = 1'b1;
      #1;
      checkValue("reset_valid_out", kValidOut, 0);
      checkValue("reset_busy", kBusy, 0);
      checkValue("reset_u", kU, 0);
      checkValue("reset_v", kV, 0);
      checkValue("reset_tag", kTagOut, 0);
      checkValue("reset_ready_in", kReadyIn, 1);
      repeat (2) @(posedge clk);
      #1;
      r = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed CT / GS / MUL / BYPASS on Q=3329");
      applyStimulus(0, MODE_CT, 1, 1, 2001, 8'd1, 2002, 1329);
      lat = 0;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         @(posedge clk);
         #1;
         if (kValidOut) lat = c;
      end
      checkValue("ct_latency", longint'(lat), 3);
      applyStimulus(0, MODE_GS, 3, 0, 2001, 8'd2, 1666, 1337);
      applyStimulus(0, MODE_GS, 0, 0, 2001, 8'd3, 0, 0);
      applyStimulus(0, MODE_MUL, 3328, 3328, 17, 8'd4, 1, 3328);
      applyStimulus(0, MODE_BYP, 5, 7, 99, 8'd5, 5, 7);
      waitDrain(0, "directed_drain");

      $display("[TB] backpressure with ready_out low");
      kReadyOut = 1'b0;
      fork
         begin
            for (int t = 1; t <= 5; t++)
               applyStimulus(0, MODE_BYP, longint'(t), longint'(10 * t), 0, 8'(t), longint'(t), longint'(10 * t));
         end
         begin
            repeat (10) @(negedge clk);
            checkValue("stall_ready_in", kReadyIn, 0);
            checkValue("stall_valid_out", kValidOut, 1);
            checkValue("stall_tag", kTagOut, 1);
            checkValue("stall_u", kU, 1);
            repeat (3) @(negedge clk);
            checkValue("stall_hold_tag", kTagOut, 1);
            checkValue("stall_hold_v", kV, 10);
            @(posedge clk);
            #1;
            kReadyOut = 1'b1;
         end
      join
      waitDrain(0, "backpressure_drain");

      $display("[TB] reset with three beats in flight");
      applyStimulus(0, MODE_CT, 1, 1, 2001, 8'd20, 2002, 1329);
      applyStimulus(0, MODE_CT, 2, 1, 2001, 8'd21, 2003, 1330);
      applyStimulus(0, MODE_CT, 3, 1, 2001, 8'd22, 2004, 1331);
      r = 1'b0;
      qK.delete();
      #1;
      checkValue("midreset_valid_out", kValidOut, 0);
      checkValue("midreset_u", kU, 0);
      checkValue("midreset_v", kV, 0);
      checkValue("midreset_tag", kTagOut, 0);
      checkValue("midreset_busy", kBusy, 0);
      repeat (2) @(posedge clk);
      #1;
      r = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (kValidOut) seen++;
      end
      checkValue("post_reset_no_beat", longint'(seen), 0);

      $display("[TB] random mixed-mode beats on Q=3329");
      @(posedge clk);
      #1;
      kRandReady = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         md = 2'($urandom_range(0, 3));
         a = $urandom_range(0, Q_KYBER - 1);
         b = $urandom_range(0, Q_KYBER - 1);
         w = $urandom_range(0, Q_KYBER - 1);
         refModel(md, a, b, w, Q_KYBER, eu, ev);
         applyStimulus(0, md, a, b, w, 8'(i), eu, ev);
      end
      kRandReady = 1'b0;
      kReadyOut = 1'b1;
      waitDrain(0, "kyber_random_drain");

      $display("[TB] Q=8380417 directed and random beats");
      applyStimulus(1, MODE_CT, 0, 1, 1, 8'hD1, 1, 8380416);
      dRandReady = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         md = 2'($urandom_range(0, 3));
         a = $urandom_range(0, Q_DILITHIUM - 1);
         b = $urandom_range(0, Q_DILITHIUM - 1);
         w = $urandom_range(0, Q_DILITHIUM - 1);
         refModel(md, a, b, w, Q_DILITHIUM, eu, ev);
         applyStimulus(1, md, a, b, w, 8'(i), eu, ev);
      end
      dRandReady = 1'b0;
      dReadyOut = 1'b1;
      waitDrain(1, "dil_random_drain");
      repeat (2) @(posedge clk);
      #1;
      checkValue("kyber_idle_busy", kBusy, 0);
      checkValue("dil_idle_busy", dBusy, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
